// File: rtl/decode_regread_unit.sv
// decode_regread_unit
//   Front-end helper for the out-of-order MIPS core. Decodes one MIPS-I
//   instruction into datapath controls, computes its branch/jump target and
//   holds the physical register file. Decode, target and reads are
//   combinational; only register-file writes are clocked.
module decode_regread_unit #(
    parameter int NPREG = 64,
    parameter int XLEN  = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [31:0]              instr,
    input  logic [31:0]              instr_pc,
    input  logic                     stall,
    input  logic                     wr_en,
    input  logic [$clog2(NPREG)-1:0] wr_preg,
    input  logic [XLEN-1:0]          wr_data,
    input  logic [$clog2(NPREG)-1:0] rd_preg_a,
    input  logic [$clog2(NPREG)-1:0] rd_preg_b,
    input  logic [$clog2(NPREG)-1:0] rd_preg_c,
    output logic [XLEN-1:0]          rd_data_a,
    output logic [XLEN-1:0]          rd_data_b,
    output logic [XLEN-1:0]          rd_data_c,
    output logic                     link,
    output logic                     reg_dest,
    output logic                     jump,
    output logic                     branch,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     alu_src,
    output logic                     reg_write,
    output logic                     jump_register,
    output logic                     sign_or_zero,
    output logic                     syscall,
    output logic [5:0]               alu_control,
    output logic [1:0]               mult_reg,
    output logic [31:0]              next_addr,
    output logic [4:0]               rs_field
);

    localparam int PW = $clog2(NPREG);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type function codes with side effects beyond the ALU
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    // REGIMM rt selectors that also link
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    logic [XLEN-1:0] regs_r [NPREG];
    logic [5:0]      op_s;
    logic [5:0]      funct_s;
    logic [4:0]      rt_s;
    logic [31:0]     pc4_s;
    logic [31:0]     br_off_s;

    assign op_s     = instr[31:26];
    assign funct_s  = instr[5:0];
    assign rt_s     = instr[20:16];
    assign rs_field = instr[25:21];

    // Physical register file: async clear, stall-gated write, preg 0 never written
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NPREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en && !stall && (wr_preg != {PW{1'b0}})) begin
            regs_r[wr_preg] <= wr_data;
        end
    end

    // Reads have no bypass: a same-cycle write is only seen after the edge
    assign rd_data_a = regs_r[rd_preg_a];
    assign rd_data_b = regs_r[rd_preg_b];
    assign rd_data_c = regs_r[rd_preg_c];

    // Instruction decode: everything defaults to 0 so unknown opcodes are inert
    always_comb begin
        link          = 1'b0;
        reg_dest      = 1'b0;
        jump          = 1'b0;
        branch        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src       = 1'b0;
        reg_write     = 1'b0;
        jump_register = 1'b0;
        sign_or_zero  = 1'b0;
        syscall       = 1'b0;
        alu_control   = 6'h00;
        mult_reg      = 2'b00;
        case (op_s)
            OP_RTYPE: begin
                reg_dest    = 1'b1;
                reg_write   = 1'b1;
                alu_control = funct_s;
                case (funct_s)
                    FN_JR: begin
                        jump          = 1'b1;
                        jump_register = 1'b1;
                        reg_write     = 1'b0;
                    end
                    FN_JALR: begin
                        jump          = 1'b1;
                        jump_register = 1'b1;
                        link          = 1'b1;
                    end
                    FN_SYSCALL: begin
                        syscall   = 1'b1;
                        reg_write = 1'b0;
                    end
                    FN_MFHI, FN_MFLO: begin
                        mult_reg = 2'b01;
                    end
                    FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        mult_reg  = 2'b10;
                        reg_write = 1'b0;
                    end
                    default: begin
                        mult_reg = 2'b00;
                    end
                endcase
            end
            OP_J: begin
                jump = 1'b1;
            end
            OP_JAL: begin
                jump      = 1'b1;
                link      = 1'b1;
                reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                branch      = 1'b1;
                alu_control = op_s;
            end
            OP_REGIMM: begin
                branch      = 1'b1;
                alu_control = 6'h01;
                if ((rt_s == RT_BLTZAL) || (rt_s == RT_BGEZAL)) begin
                    link      = 1'b1;
                    reg_write = 1'b1;
                end else begin
                    link      = 1'b0;
                    reg_write = 1'b0;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI: begin
                alu_src      = 1'b1;
                reg_write    = 1'b1;
                sign_or_zero = 1'b1;
                case (op_s)
                    OP_SLTI:  alu_control = 6'h2A;
                    OP_SLTIU: alu_control = 6'h2B;
                    OP_LUI:   alu_control = 6'h3F;
                    default:  alu_control = 6'h21;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                // Logical immediates are zero-extended
                alu_src   = 1'b1;
                reg_write = 1'b1;
                case (op_s)
                    OP_ANDI: alu_control = 6'h24;
                    OP_ORI:  alu_control = 6'h25;
                    default: alu_control = 6'h26;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                mem_read     = 1'b1;
                reg_write    = 1'b1;
                alu_src      = 1'b1;
                sign_or_zero = 1'b1;
                alu_control  = 6'h21;
            end
            OP_SB, OP_SH, OP_SW: begin
                mem_write    = 1'b1;
                alu_src      = 1'b1;
                sign_or_zero = 1'b1;
                alu_control  = 6'h21;
            end
            default: begin
                alu_control = 6'h00;
            end
        endcase
    end

    assign pc4_s    = instr_pc + 32'd4;
    assign br_off_s = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Target select: register jump, pseudo-direct jump, or PC-relative branch
    always_comb begin
        next_addr = 32'h0000_0000;
        if (jump && jump_register) begin
            next_addr = rd_data_a[31:0];
        end else if (jump) begin
            next_addr = {pc4_s[31:28], instr[25:0], 2'b00};
        end else begin
            next_addr = pc4_s + br_off_s;
        end
    end

endmodule

// File: tb/tb_decode_regread_unit.sv
// Testbench for decode_regread_unit: directed checks followed by randomized
// decode/register traffic compared against a table-driven reference model.
module tb_decode_regread_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        wr_en;
    logic [5:0]  wr_preg;
    logic [31:0] wr_data;
    logic [5:0]  rd_preg_a;
    logic [5:0]  rd_preg_b;
    logic [5:0]  rd_preg_c;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic [31:0] rd_data_c;
    logic        link, reg_dest, jump, branch, mem_read, mem_write, alu_src;
    logic        reg_write, jump_register, sign_or_zero, syscall;
    logic [5:0]  alu_control;
    logic [1:0]  mult_reg;
    logic [31:0] next_addr;
    logic [4:0]  rs_field;

    typedef struct packed {
        logic       link;
        logic       reg_dest;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump_register;
        logic       sign_or_zero;
        logic       syscall;
        logic [5:0] alu_control;
        logic [1:0] mult_reg;
    } ctrl_t;

    int          tests;
    int          fails;
    logic [31:0] ref_regs [64];
    ctrl_t       obs_ctrl;

    logic [5:0] imm_alu_tbl [8]  = '{6'h21, 6'h21, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26, 6'h3F};
    logic [5:0] op_list     [27] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                     6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                     6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3E};
    logic [5:0] fn_list     [14] = '{6'h08, 6'h09, 6'h0C, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18,
                                     6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h2A};
    logic [4:0] rt_list     [4]  = '{5'h00, 5'h01, 5'h10, 5'h11};

    decode_regread_unit dut (
        .CLK(CLK), .RESET(RESET), .instr(instr), .instr_pc(instr_pc), .stall(stall),
        .wr_en(wr_en), .wr_preg(wr_preg), .wr_data(wr_data),
        .rd_preg_a(rd_preg_a), .rd_preg_b(rd_preg_b), .rd_preg_c(rd_preg_c),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
        .link(link), .reg_dest(reg_dest), .jump(jump), .branch(branch),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .jump_register(jump_register),
        .sign_or_zero(sign_or_zero), .syscall(syscall),
        .alu_control(alu_control), .mult_reg(mult_reg),
        .next_addr(next_addr), .rs_field(rs_field)
    );

    assign obs_ctrl = {link, reg_dest, jump, branch, mem_read, mem_write, alu_src,
                       reg_write, jump_register, sign_or_zero, syscall, alu_control, mult_reg};

    always #5 CLK = ~CLK;

    // Reference decode, built from the instruction-class rules
    function automatic ctrl_t model_ctrl(input logic [31:0] ins);
        ctrl_t      c;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        c  = '0;
        op = ins[31:26];
        fn = ins[5:0];
        rt = ins[20:16];
        if (op == 6'h00) begin
            c.reg_dest    = 1'b1;
            c.reg_write   = 1'b1;
            c.alu_control = fn;
            if (fn == 6'h08) begin
                c.jump = 1'b1; c.jump_register = 1'b1; c.reg_write = 1'b0;
            end
            if (fn == 6'h09) begin
                c.jump = 1'b1; c.jump_register = 1'b1; c.link = 1'b1;
            end
            if (fn == 6'h0C) begin
                c.syscall = 1'b1; c.reg_write = 1'b0;
            end
            if (fn inside {6'h10, 6'h12}) c.mult_reg = 2'b01;
            if (fn inside {6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B}) begin
                c.mult_reg = 2'b10; c.reg_write = 1'b0;
            end
        end else if (op == 6'h02) begin
            c.jump = 1'b1;
        end else if (op == 6'h03) begin
            c.jump = 1'b1; c.link = 1'b1; c.reg_write = 1'b1;
        end else if (op == 6'h01 || (op >= 6'h04 && op <= 6'h07)) begin
            c.branch      = 1'b1;
            c.alu_control = op;
            if (op == 6'h01 && (rt == 5'h10 || rt == 5'h11)) begin
                c.link = 1'b1; c.reg_write = 1'b1;
            end
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            c.alu_src      = 1'b1;
            c.reg_write    = 1'b1;
            c.alu_control  = imm_alu_tbl[op - 6'h08];
            c.sign_or_zero = !(op inside {6'h0C, 6'h0D, 6'h0E});
        end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            c.mem_read = 1'b1; c.reg_write = 1'b1; c.alu_src = 1'b1;
            c.sign_or_zero = 1'b1; c.alu_control = 6'h21;
        end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
            c.mem_write = 1'b1; c.alu_src = 1'b1;
            c.sign_or_zero = 1'b1; c.alu_control = 6'h21;
        end
        return c;
    endfunction

    // Reference target using plain integer arithmetic
    function automatic logic [31:0] model_next(input logic [31:0] ins, input logic [31:0] pc,
                                               input logic [31:0] ra_val);
        ctrl_t       c;
        logic [31:0] pc4;
        int          off;
        c   = model_ctrl(ins);
        pc4 = pc + 32'd4;
        if (c.jump && c.jump_register) return ra_val;
        if (c.jump) return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        off = $signed(ins[15:0]);
        off = off * 4;
        return pc4 + 32'(off);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        if ($urandom_range(0, 9) < 8) ins[31:26] = op_list[$urandom_range(0, 26)];
        if (ins[31:26] == 6'h00 && $urandom_range(0, 1) == 1) ins[5:0] = fn_list[$urandom_range(0, 13)];
        if (ins[31:26] == 6'h01 && $urandom_range(0, 1) == 1) ins[20:16] = rt_list[$urandom_range(0, 3)];
        return ins;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and mirror the write the bench requested
    task automatic tick();
        @(posedge CLK);
        if (wr_en && !stall && wr_preg != 6'd0) ref_regs[wr_preg] = wr_data;
        #1;
    endtask

    task automatic check_all(input string tag);
        ctrl_t e;
        e = model_ctrl(instr);
        chk({tag, "_rda"}, rd_data_a, ref_regs[rd_preg_a]);
        chk({tag, "_rdb"}, rd_data_b, ref_regs[rd_preg_b]);
        chk({tag, "_rdc"}, rd_data_c, ref_regs[rd_preg_c]);
        chk({tag, "_ctrl"}, {13'd0, obs_ctrl}, {13'd0, e});
        chk({tag, "_next"}, next_addr, model_next(instr, instr_pc, ref_regs[rd_preg_a]));
        chk({tag, "_rs"}, {27'd0, rs_field}, (instr >> 21) & 32'h1F);
    endtask

    initial begin
        tests = 0; fails = 0;
        CLK = 1'b0; RESET = 1'b0;
        instr = 32'd0; instr_pc = 32'd0; stall = 1'b0;
        wr_en = 1'b0; wr_preg = 6'd0; wr_data = 32'd0;
        rd_preg_a = 6'd0; rd_preg_b = 6'd0; rd_preg_c = 6'd0;
        for (int i = 0; i < 64; i++) ref_regs[i] = 32'd0;
        #12;
        // Reset state: every register reads zero on every port
        for (int i = 0; i < 64; i++) begin
            rd_preg_a = 6'(i); rd_preg_b = 6'(63 - i); rd_preg_c = 6'(i);
            #1;
            chk("rst_a", rd_data_a, 32'd0);
            chk("rst_b", rd_data_b, 32'd0);
            chk("rst_c", rd_data_c, 32'd0);
        end
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;

        // Write preg 5; same-cycle read is the old value
        wr_en = 1'b1; wr_preg = 6'd5; wr_data = 32'hDEAD_BEEF; rd_preg_a = 6'd5;
        #2;
        chk("same_cycle_old", rd_data_a, 32'd0);
        tick();
        wr_en = 1'b0; #1;
        chk("wr5", rd_data_a, 32'hDEAD_BEEF);

        // Preg 0 stays zero
        wr_en = 1'b1; wr_preg = 6'd0; wr_data = 32'h0000_1234; rd_preg_b = 6'd0;
        tick();
        wr_en = 1'b0; #1;
        chk("wr0", rd_data_b, 32'd0);

        // Stalled write is dropped
        wr_en = 1'b1; stall = 1'b1; wr_preg = 6'd5; wr_data = 32'h1111_1111;
        tick();
        wr_en = 1'b0; stall = 1'b0; #1;
        chk("stall", rd_data_a, 32'hDEAD_BEEF);

        // add $2,$4,$5
        instr = 32'h0085_1020; #1;
        chk("add_ctrl", {13'd0, obs_ctrl}, 32'h0002_0880);
        chk("add_alu", {26'd0, alu_control}, 32'h20);

        // beq with offset -1 at 0x100 branches to itself
        instr = 32'h1000_FFFF; instr_pc = 32'h0000_0100; #1;
        chk("beq_branch", {31'd0, branch}, 32'd1);
        chk("beq_next", next_addr, 32'h0000_0100);

        // jal 0x100
        instr = 32'h0C00_0040; #1;
        chk("jal_jl", {30'd0, jump, link}, 32'd3);
        chk("jal_next", next_addr, 32'h0000_0100);

        // jr $31 with the target held in preg 7
        wr_en = 1'b1; wr_preg = 6'd7; wr_data = 32'h0040_0020;
        tick();
        wr_en = 1'b0; rd_preg_a = 6'd7; instr = 32'h03E0_0008; #1;
        chk("jr_jjr", {30'd0, jump, jump_register}, 32'd3);
        chk("jr_next", next_addr, 32'h0040_0020);
        chk("jr_rs", {27'd0, rs_field}, 32'd31);

        // lw and ori
        instr = 32'h8C82_0004; #1;
        chk("lw_ms", {30'd0, mem_read, alu_src}, 32'd3);
        chk("lw_alu", {26'd0, alu_control}, 32'h21);
        instr = 32'h3442_0001; #1;
        chk("ori_soz", {31'd0, sign_or_zero}, 32'd0);
        chk("ori_alu", {26'd0, alu_control}, 32'h25);

        // Asynchronous reset mid-cycle clears the file immediately
        RESET = 1'b0; #1;
        chk("async_rst", rd_data_a, 32'd0);
        for (int i = 0; i < 64; i++) ref_regs[i] = 32'd0;
        #2; RESET = 1'b1;
        @(posedge CLK); #1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            wr_en    = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            wr_preg  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            wr_data  = $urandom;
            rd_preg_a = ($urandom_range(0, 3) == 0) ? wr_preg : 6'($urandom_range(0, 63));
            rd_preg_b = 6'($urandom_range(0, 63));
            rd_preg_c = ($urandom_range(0, 3) == 0) ? wr_preg : 6'($urandom_range(0, 63));
            instr    = rand_instr();
            instr_pc = $urandom;
            #2;
            check_all("rnd");
            tick();
        end

        // Final readback of the whole file
        wr_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rd_preg_a = 6'(i); rd_preg_b = 6'(i); rd_preg_c = 6'(i);
            #1;
            chk("final", rd_data_c, ref_regs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
